lfsr_stream: RTL and testbench
==============================

// Module: lfsr_stream
// PURPOSE
//  Parametrised successor of the single-bit LFSR. Fibonacci or Galois mode, runtime seed load,
//  external entropy injection and all-zero lockup recovery. Packs one output bit per LFSR step
//  into OUT_WIDTH-bit words on a valid/ready stream. Feeds test-pattern generators, scramblers
//  and dither sources.
// PARAMETERS
//  WIDTH      16       LFSR state width, >= 3
//  MODE       0        0 = Fibonacci, 1 = Galois (constants in lfsr_pkg.vh)
//  TAPS       16'h002D feedback mask, WIDTH bits; TAPS[WIDTH-1] ignored in Galois mode
//  INIT_VALUE 16'hACE1 state after reset and after lockup recovery; must be non-zero
//  OUT_WIDTH  8        bits per output word, 1..32
// PORTS
//  clk            in   1          clock; all logic on posedge
//  rst            in   1          synchronous reset, active-high
//  seed_valid     in   1          load seed_data into state this cycle
//  seed_data      in   WIDTH      new state; zero value is replaced by INIT_VALUE
//  entropy_valid  in   1          entropy_bit is meaningful this cycle
//  entropy_bit    in   1          XORed into the feedback of a step cycle
//  out_valid      out  1          out_data holds a complete word
//  out_ready      in   1          consumer accepts the word
//  out_data       out  OUT_WIDTH  packed LFSR output bits, first-generated bit in bit 0
//  state          out  WIDTH      current LFSR state
//  lockup         out  1          one-cycle pulse: all-zero state detected and repaired
// BEHAVIOUR
//  Reset values: state=INIT_VALUE, out_valid=0, out_data=0, lockup=0, accumulator cleared.
//  Step cycle: state advances once. ent = entropy_valid & entropy_bit. Output bit is state[0].
//   Fibonacci: fb = ent ^ ^(state & TAPS); next = {fb, state[WIDTH-1:1]}.
//   Galois: b = state[0]; next = {b ^ ent, state[WIDTH-1:1]} ^ ({WIDTH{b}} & {1'b0, TAPS[WIDTH-2:0]}).
//  Entropy presented on a non-step cycle is dropped and is not queued.
//  Buffering has two stages:
//   - Accumulator: a shift register plus a bit counter, 0..OUT_WIDTH-1.
//   - Holding register: drives out_data and out_valid.
//  Word completion: when the accumulator receives its OUT_WIDTH-th bit, the completed word moves
//   to the holding register in the same edge if the holding register is free, or being read
//   this cycle (out_valid & out_ready). The counter wraps to 0.
//  Stall: the step is suppressed only when the accumulator has OUT_WIDTH-1 bits and the holding
//   register is occupied and not read this cycle. No bit is ever lost or duplicated.
//  Latency: after reset, first out_valid rises at the edge ending the OUT_WIDTH-th step cycle.
//   With no stalls, one word is produced every OUT_WIDTH cycles.
//  out_data is stable while out_valid=1 and out_ready=0.
//  Priority, per cycle: rst > seed_valid > lockup repair > step.
//   seed_valid: state<=seed_data (INIT_VALUE if zero). Accumulator cleared, holding register
//    invalidated (out_valid<=0). No step that cycle.
//   Lockup: if state==0 at a clock edge (only reachable via entropy), state<=INIT_VALUE and
//    lockup=1 for that one cycle. The accumulator keeps its bits. No step that cycle.
//  Mid-word reset or seed drops the partial word silently. A seed arriving in the same cycle
//   as an out handshake still completes that handshake, then invalidates.
// STRUCTURE
//  lfsr_pkg.vh: MODE_FIBONACCI=0 and MODE_GALOIS=1 localparams, default TAPS and INIT_VALUE.
//  Sub-module lfsr_next: purely combinational (state, ent, MODE, TAPS) -> (next, out_bit).
//  Top level holds the state register, accumulator, holding register, stall and priority logic.
// TESTING
//  Reset: defaults -> state=16'hACE1, out_valid=0; step 1 -> 16'h5670 (bit 1); step 2 -> 16'hAB38 (bit 0).
//  Stream, out_ready=1: out_valid rises 8 cycles after reset. Bits 0..1 of word 0 are 1,0.
//   Words match a reference model for 64 words with no gaps.
//  Backpressure: out_ready=0 for 30 cycles -> exactly one held word plus 7 accumulated bits,
//   state frozen. Release -> next words contiguous with the model, no lost bits.
//  Seed: seed_data=16'h0001 mid-word -> out_valid=0, counter=0, state=16'h0001.
//   seed_data=0 -> state=16'hACE1.
//  Lockup: state=16'h0001 and entropy forcing fb=0 -> state 0 -> next cycle lockup=1, state=16'hACE1.
//  Galois: MODE=1, TAPS=16'hB400, seed 16'h0001 -> period 65535 with no repeat before it.

Source files
------------

// File: rtl/lfsr_stream_pkg.sv
// lfsr_stream_pkg: LFSR mode selectors and default 16-bit polynomial/seed
package lfsr_stream_pkg;
    localparam int          MODE_FIBONACCI = 0;
    localparam int          MODE_GALOIS    = 1;
    localparam logic [15:0] DEFAULT_TAPS   = 16'h002D;
    localparam logic [15:0] DEFAULT_INIT   = 16'hACE1;
endpackage

// File: rtl/lfsr_stream_next.sv
// lfsr_stream_next: combinational one-step LFSR successor (Fibonacci or Galois)
//   i_state/i_ent in -> o_next state, o_bit output bit (state[0])
module lfsr_stream_next
    import lfsr_stream_pkg::*;
#(
    parameter int               WIDTH = 16,
    parameter int               MODE  = MODE_FIBONACCI,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEFAULT_TAPS)
) (
    input  logic [WIDTH-1:0] i_state,
    input  logic             i_ent,
    output logic [WIDTH-1:0] o_next,
    output logic             o_bit
);
    logic [WIDTH-1:0] w_mask;
    // The top tap is implied by the shifted-in bit in Galois form
    assign w_mask = {1'b0, TAPS[WIDTH-2:0]};
    assign o_bit  = i_state[0];
    assign o_next = (MODE == MODE_GALOIS)
        ? ({i_state[0] ^ i_ent, i_state[WIDTH-1:1]} ^ ({WIDTH{i_state[0]}} & w_mask))
        : {i_ent ^ (^(i_state & TAPS)), i_state[WIDTH-1:1]};
endmodule

// File: rtl/lfsr_stream.sv
// lfsr_stream: LFSR bit generator packed into OUT_WIDTH-bit valid/ready words
//   seed_valid/seed_data load state, entropy_* perturb feedback, out_* stream,
//   state mirrors the LFSR, lockup pulses when an all-zero state is repaired
module lfsr_stream
    import lfsr_stream_pkg::*;
#(
    parameter int               WIDTH      = 16,
    parameter int               MODE       = MODE_FIBONACCI,
    parameter logic [WIDTH-1:0] TAPS       = WIDTH'(DEFAULT_TAPS),
    parameter logic [WIDTH-1:0] INIT_VALUE = WIDTH'(DEFAULT_INIT),
    parameter int               OUT_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 seed_valid,
    input  logic [WIDTH-1:0]     seed_data,
    input  logic                 entropy_valid,
    input  logic                 entropy_bit,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic [WIDTH-1:0]     state,
    output logic                 lockup
);
    localparam int CW = OUT_WIDTH > 1 ? $clog2(OUT_WIDTH) : 1;

    logic [WIDTH-1:0]     r_state;
    logic [OUT_WIDTH-1:0] r_acc;
    logic [CW-1:0]        r_cnt;
    logic [OUT_WIDTH-1:0] r_hold;
    logic                 r_valid;
    logic                 r_lockup;

    logic [WIDTH-1:0]     w_next;
    logic [OUT_WIDTH-1:0] w_acc;
    logic                 w_bit, w_read, w_last, w_stall, w_zero, w_step;

    lfsr_stream_next #(.WIDTH(WIDTH), .MODE(MODE), .TAPS(TAPS)) u_next (
        .i_state (r_state),
        .i_ent   (entropy_valid & entropy_bit),
        .o_next  (w_next),
        .o_bit   (w_bit)
    );

    assign w_read  = r_valid & out_ready;
    assign w_last  = r_cnt == CW'(OUT_WIDTH - 1);
    // Only the word-completing step needs the holding register, so only it can stall
    assign w_stall = w_last & r_valid & ~out_ready;
    assign w_zero  = r_state == '0;
    assign w_step  = ~w_zero & ~w_stall;
    // Shift right so the first-generated bit lands in bit 0 after OUT_WIDTH steps
    assign w_acc   = (r_acc >> 1) | (OUT_WIDTH'(w_bit) << (OUT_WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= INIT_VALUE;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_hold   <= '0;
            r_valid  <= 1'b0;
            r_lockup <= 1'b0;
        end else begin
            r_lockup <= w_zero & ~seed_valid;
            if (seed_valid) begin
                r_state <= (seed_data == '0) ? INIT_VALUE : seed_data;
                r_acc   <= '0;
                r_cnt   <= '0;
                r_valid <= 1'b0;
            end else begin
                if (w_read) r_valid <= 1'b0;
                if (w_zero) begin
                    r_state <= INIT_VALUE;
                end else if (w_step) begin
                    r_state <= w_next;
                    r_acc   <= w_acc;
                    r_cnt   <= w_last ? '0 : r_cnt + CW'(1);
                    if (w_last) begin
                        r_hold  <= w_acc;
                        r_valid <= 1'b1;
                    end
                end
            end
        end
    end

    assign out_valid = r_valid;
    assign out_data  = r_hold;
    assign state     = r_state;
    assign lockup    = r_lockup;
endmodule

// File: tb/tb_lfsr_stream.sv
// tb_lfsr_stream: directed checks of reset, streaming, backpressure, seed, lockup and Galois period
module tb_lfsr_stream;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        seed_valid = 1'b0, entropy_valid = 1'b0, entropy_bit = 1'b0, out_ready = 1'b1;
    logic [15:0] seed_data = '0;
    logic        out_valid, lockup;
    logic [7:0]  out_data;
    logic [15:0] state;
    logic        g_seed_valid = 1'b0, g_out_valid, g_lockup;
    logic [15:0] g_seed_data = '0, g_state;
    logic [7:0]  g_out_data;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] m_state;
    logic [7:0]  m_word, hold_word;
    int          m_n;

    always #5 clk = ~clk;

    lfsr_stream dut (
        .clk(clk), .rst(rst), .seed_valid(seed_valid), .seed_data(seed_data),
        .entropy_valid(entropy_valid), .entropy_bit(entropy_bit),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .state(state), .lockup(lockup)
    );

    lfsr_stream #(.MODE(1), .TAPS(16'hB400)) dut_g (
        .clk(clk), .rst(rst), .seed_valid(g_seed_valid), .seed_data(g_seed_data),
        .entropy_valid(1'b0), .entropy_bit(1'b0),
        .out_valid(g_out_valid), .out_ready(1'b1), .out_data(g_out_data),
        .state(g_state), .lockup(g_lockup)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mstep();
        m_word  = {m_state[0], m_word[7:1]};
        m_n++;
        m_state = {m_state[0] ^ m_state[2] ^ m_state[3] ^ m_state[5], m_state[15:1]};
    endtask

    task automatic stream_cycle(input string tag);
        tick();
        mstep();
        if (m_n == 8) begin
            m_n = 0;
            chk({tag, "_valid"}, 32'(out_valid), 32'd1);
            chk({tag, "_data"}, 32'(out_data), 32'(m_word));
            chk({tag, "_state"}, 32'(state), 32'(m_state));
        end else begin
            chk({tag, "_gap"}, 32'(out_valid), 32'd0);
        end
    endtask

    initial begin
        int n;
        repeat (2) tick();
        rst = 1'b0;
        chk("rst_state", 32'(state), 32'hACE1);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_lockup", 32'(lockup), 32'd0);

        m_state = 16'hACE1;
        m_word  = '0;
        m_n     = 0;
        for (int c = 1; c <= 512; c++) begin
            stream_cycle("stream");
            if (c == 1) chk("step1", 32'(state), 32'h5670);
            if (c == 2) chk("step2", 32'(state), 32'hAB38);
            if (c == 8) chk("word0_bits", 32'(out_data[1:0]), 32'h1);
        end

        out_ready = 1'b0;
        hold_word = m_word;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (i < 7) mstep();
            chk("bp_held", 32'({out_valid, out_data}), 32'({1'b1, hold_word}));
        end
        chk("bp_state", 32'(state), 32'(m_state));
        out_ready = 1'b1;
        for (int i = 0; i < 24; i++) stream_cycle("release");

        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            mstep();
        end
        seed_valid = 1'b1;
        seed_data  = 16'h0001;
        tick();
        seed_valid = 1'b0;
        out_ready  = 1'b1;
        chk("seed_valid", 32'(out_valid), 32'd0);
        chk("seed_state", 32'(state), 32'h0001);
        m_state = 16'h0001;
        m_word  = '0;
        m_n     = 0;
        for (int i = 0; i < 16; i++) stream_cycle("seeded");

        seed_valid = 1'b1;
        seed_data  = 16'h0000;
        tick();
        chk("seed_zero", 32'(state), 32'hACE1);

        seed_data = 16'h0001;
        tick();
        seed_valid    = 1'b0;
        entropy_valid = 1'b1;
        entropy_bit   = 1'b1;
        tick();
        entropy_valid = 1'b0;
        entropy_bit   = 1'b0;
        chk("lock_zero", 32'(state), 32'h0000);
        chk("lock_pre", 32'(lockup), 32'd0);
        tick();
        chk("lock_pulse", 32'(lockup), 32'd1);
        chk("lock_repair", 32'(state), 32'hACE1);
        tick();
        chk("lock_end", 32'(lockup), 32'd0);
        chk("lock_step", 32'(state), 32'h5670);

        g_seed_valid = 1'b1;
        g_seed_data  = 16'h0001;
        tick();
        g_seed_valid = 1'b0;
        chk("gal_seed", 32'(g_state), 32'h0001);
        n = 0;
        do begin
            tick();
            n++;
            if (n == 1) chk("gal_step1", 32'(g_state), 32'hB400);
        end while (g_state != 16'h0001 && n < 70000);
        chk("gal_period", 32'(n), 32'd65535);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
